// File: rtl/wm_pkg.sv
// wm_pkg: definitions shared by the washing-machine plant model and the
// controller bench.
//   wm_phase_e      - phase FSM state encoding (3 bits)
//   WM_FULL_LEVEL   - default level at which the drum counts as full
//   WM_CYCLE_TICKS  - default wash duration in ticks
//   WM_SPIN_TICKS   - default spin duration in ticks
package wm_pkg;

   typedef enum logic [2:0] {
      PH_IDLE      = 3'd0,
      PH_WASH      = 3'd1,
      PH_WASH_DONE = 3'd2,
      PH_SPIN      = 3'd3,
      PH_SPIN_DONE = 3'd4
   } wm_phase_e;

   localparam int WM_FULL_LEVEL  = 200;
   localparam int WM_CYCLE_TICKS = 1000;
   localparam int WM_SPIN_TICKS  = 500;

endpackage

// File: rtl/wm_level_counter.sv
// wm_level_counter: saturating water level register with full/empty decode.
// Ports:
//   clk, reset      - clock, asynchronous active-high reset
//   tick            - time-base strobe; the level moves only on tick cycles
//   fill_valve_on   - raise the level by FILL_STEP (saturates at 2^LEVEL_W-1)
//   drain_valve_on  - lower the level by DRAIN_STEP (saturates at 0)
//   level           - current water level
//   filled          - level >= FULL_LEVEL (registered, tracks level)
//   drained         - level == 0 (registered, tracks level)
module wm_level_counter
   import wm_pkg::*;
#(
   parameter int LEVEL_W    = 8,
   parameter int FULL_LEVEL = WM_FULL_LEVEL,
   parameter int FILL_STEP  = 4,
   parameter int DRAIN_STEP = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               tick,
   input  logic               fill_valve_on,
   input  logic               drain_valve_on,
   output logic [LEVEL_W-1:0] level,
   output logic               filled,
   output logic               drained
);

   localparam logic [LEVEL_W:0] MAX_EXT   = {1'b0, {LEVEL_W{1'b1}}};
   localparam logic [LEVEL_W:0] FILL_EXT  = (LEVEL_W+1)'(FILL_STEP);
   localparam logic [LEVEL_W:0] DRAIN_EXT = (LEVEL_W+1)'(DRAIN_STEP);
   localparam logic [LEVEL_W:0] FULL_EXT  = (LEVEL_W+1)'(FULL_LEVEL);

   logic [LEVEL_W:0]   sum_ext;
   logic [LEVEL_W:0]   diff_ext;
   logic [LEVEL_W-1:0] level_next;

   // One extra bit catches overflow on fill and the borrow on drain.
   assign sum_ext  = {1'b0, level} + FILL_EXT;
   assign diff_ext = {1'b0, level} - DRAIN_EXT;

   always_comb begin
      level_next = level;
      if (tick && fill_valve_on && !drain_valve_on) begin
         level_next = (sum_ext > MAX_EXT) ? MAX_EXT[LEVEL_W-1:0] : sum_ext[LEVEL_W-1:0];
      end else if (tick && drain_valve_on && !fill_valve_on) begin
         level_next = diff_ext[LEVEL_W] ? '0 : diff_ext[LEVEL_W-1:0];
      end
   end

   // Flags decode the next level so they move on the same edge as level.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         level   <= '0;
         filled  <= 1'b0;
         drained <= 1'b1;
      end else begin
         level   <= level_next;
         filled  <= ({1'b0, level_next} >= FULL_EXT);
         drained <= (level_next == '0);
      end
   end

endmodule

// File: rtl/wm_plant_sense.sv
// wm_plant_sense: plant model and sensor generator for the washing machine
// controller. Turns actuator outputs into level sensors and phase timeouts.
// Optional feature macro: WM_PLANT_FAULT_EN enables sticky fault detection;
// without it the fault port is tied to 0.
// Ports:
//   clk, reset       - clock, asynchronous active-high reset
//   tick             - time-base strobe for level and timer updates
//   fill_valve_on    - fill actuator
//   drain_valve_on   - drain actuator
//   motor_on         - drum motor; starts/abandons a phase
//   door_lock        - door lock actuator (fault detection only)
//   water_level      - current level
//   filled, drained  - level sensors
//   cycle_timeout    - high while the wash phase is complete
//   spin_timeout     - high while the spin phase is complete
//   fault            - sticky fault flag
//
// state        | meaning
// PH_IDLE      | motor off, no phase running
// PH_WASH      | wash phase, counting ticks toward CYCLE_TICKS
// PH_WASH_DONE | wash complete, cycle_timeout held high
// PH_SPIN      | spin phase, counting ticks toward SPIN_TICKS
// PH_SPIN_DONE | spin complete, spin_timeout held high
module wm_plant_sense
   import wm_pkg::*;
#(
   parameter int LEVEL_W     = 8,
   parameter int FULL_LEVEL  = WM_FULL_LEVEL,
   parameter int FILL_STEP   = 4,
   parameter int DRAIN_STEP  = 8,
   parameter int TIMER_W     = 16,
   parameter int CYCLE_TICKS = WM_CYCLE_TICKS,
   parameter int SPIN_TICKS  = WM_SPIN_TICKS
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               tick,
   input  logic               fill_valve_on,
   input  logic               drain_valve_on,
   input  logic               motor_on,
   input  logic               door_lock,
   output logic [LEVEL_W-1:0] water_level,
   output logic               filled,
   output logic               drained,
   output logic               cycle_timeout,
   output logic               spin_timeout,
   output logic               fault
);

   localparam logic [TIMER_W-1:0] CYCLE_LAST = TIMER_W'(CYCLE_TICKS - 1);
   localparam logic [TIMER_W-1:0] SPIN_LAST  = TIMER_W'(SPIN_TICKS - 1);

   wm_phase_e          phase;
   logic [TIMER_W-1:0] cnt;

   wm_level_counter #(
      .LEVEL_W    (LEVEL_W),
      .FULL_LEVEL (FULL_LEVEL),
      .FILL_STEP  (FILL_STEP),
      .DRAIN_STEP (DRAIN_STEP)
   ) u_level (
      .clk            (clk),
      .reset          (reset),
      .tick           (tick),
      .fill_valve_on  (fill_valve_on),
      .drain_valve_on (drain_valve_on),
      .level          (water_level),
      .filled         (filled),
      .drained        (drained)
   );

   // Motor dropping out abandons the phase before any timer completion.
   // The entry cycle only picks the phase; its tick is not counted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase         <= PH_IDLE;
         cnt           <= '0;
         cycle_timeout <= 1'b0;
         spin_timeout  <= 1'b0;
      end else if (phase != PH_IDLE && !motor_on) begin
         phase         <= PH_IDLE;
         cnt           <= '0;
         cycle_timeout <= 1'b0;
         spin_timeout  <= 1'b0;
      end else begin
         case (phase)
            PH_IDLE: begin
               if (motor_on) begin
                  phase <= drained ? PH_SPIN : PH_WASH;
                  cnt   <= '0;
               end
            end
            PH_WASH: begin
               if (tick) begin
                  if (cnt == CYCLE_LAST) begin
                     phase         <= PH_WASH_DONE;
                     cnt           <= '0;
                     cycle_timeout <= 1'b1;
                  end else begin
                     cnt <= cnt + TIMER_W'(1);
                  end
               end
            end
            PH_SPIN: begin
               if (tick) begin
                  if (cnt == SPIN_LAST) begin
                     phase        <= PH_SPIN_DONE;
                     cnt          <= '0;
                     spin_timeout <= 1'b1;
                  end else begin
                     cnt <= cnt + TIMER_W'(1);
                  end
               end
            end
            default: begin
               // Done states hold until the motor stops.
            end
         endcase
      end
   end

`ifdef WM_PLANT_FAULT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fault <= 1'b0;
      end else if ((tick && fill_valve_on && drain_valve_on) || (motor_on && !door_lock)) begin
         fault <= 1'b1;
      end
   end
`else
   logic unused_door_lock;
   assign unused_door_lock = door_lock;
   assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_wm_plant_sense.sv
// tb_wm_plant_sense: directed and randomized closed-loop stimulus for
// wm_plant_sense. Stimulus pushes the expected outputs of a behavioural
// plant model into a queue; a monitor pops and compares one entry per edge.
module tb_wm_plant_sense;
   import wm_pkg::*;

   localparam int FULL  = WM_FULL_LEVEL;
   localparam int CYC   = WM_CYCLE_TICKS;
   localparam int SPN   = WM_SPIN_TICKS;
   localparam int FSTEP = 4;
   localparam int DSTEP = 8;
   localparam int LMAX  = 255;

   logic       clk = 1'b0;
   logic       reset;
   logic       tick;
   logic       fill_valve_on;
   logic       drain_valve_on;
   logic       motor_on;
   logic       door_lock;
   logic [7:0] water_level;
   logic       filled;
   logic       drained;
   logic       cycle_timeout;
   logic       spin_timeout;
   logic       fault;

   always #5 clk = ~clk;

   wm_plant_sense #(
      .LEVEL_W     (8),
      .FULL_LEVEL  (FULL),
      .FILL_STEP   (FSTEP),
      .DRAIN_STEP  (DSTEP),
      .TIMER_W     (16),
      .CYCLE_TICKS (CYC),
      .SPIN_TICKS  (SPN)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .tick           (tick),
      .fill_valve_on  (fill_valve_on),
      .drain_valve_on (drain_valve_on),
      .motor_on       (motor_on),
      .door_lock      (door_lock),
      .water_level    (water_level),
      .filled         (filled),
      .drained        (drained),
      .cycle_timeout  (cycle_timeout),
      .spin_timeout   (spin_timeout),
      .fault          (fault)
   );

   typedef struct {
      int lvl;
      bit filled;
      bit drained;
      bit cto;
      bit sto;
      bit fault;
   } exp_t;

   exp_t exp_q[$];
   int   n_pass  = 0;
   int   n_total = 0;

   // Plant model: a level, and a running phase described by its kind and
   // how many ticks it has accumulated since the motor started.
   int m_lvl;
   bit m_active;
   bit m_spin;
   int m_ticks;
   bit m_fault;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
      n_total++;
      if (act !== req) $display("FAIL %s: got %0d, expected %0d", name, act, req);
      else n_pass++;
   endtask

   task automatic model_reset();
      m_lvl    = 0;
      m_active = 1'b0;
      m_spin   = 1'b0;
      m_ticks  = 0;
      m_fault  = 1'b0;
   endtask

   task automatic model_edge(input bit t, input bit f, input bit d, input bit m, input bit l);
      int dur;
      if (m_active && !m) begin
         m_active = 1'b0;
         m_ticks  = 0;
      end else if (!m_active && m) begin
         m_active = 1'b1;
         m_spin   = (m_lvl == 0);
         m_ticks  = 0;
      end else if (m_active && t) begin
         dur = m_spin ? SPN : CYC;
         if (m_ticks < dur) m_ticks++;
      end
`ifdef WM_PLANT_FAULT_EN
      if ((t && f && d) || (m && !l)) m_fault = 1'b1;
`endif
      if (t && f && !d) m_lvl = (m_lvl + FSTEP > LMAX) ? LMAX : m_lvl + FSTEP;
      else if (t && d && !f) m_lvl = (m_lvl < DSTEP) ? 0 : m_lvl - DSTEP;
   endtask

   function automatic exp_t model_out();
      exp_t e;
      e.lvl     = m_lvl;
      e.filled  = (m_lvl >= FULL);
      e.drained = (m_lvl == 0);
      e.cto     = m_active && !m_spin && (m_ticks >= CYC);
      e.sto     = m_active && m_spin && (m_ticks >= SPN);
      e.fault   = m_fault;
      return e;
   endfunction

   task automatic step(input bit t, input bit f, input bit d, input bit m, input bit l,
                       input bit r = 1'b0);
      @(negedge clk);
      reset          = r;
      tick           = t;
      fill_valve_on  = f;
      drain_valve_on = d;
      motor_on       = m;
      door_lock      = l;
      if (r) model_reset();
      else model_edge(t, f, d, m, l);
      exp_q.push_back(model_out());
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("level",         water_level,   e.lvl);
            chk("filled",        filled,        e.filled);
            chk("drained",       drained,       e.drained);
            chk("cycle_timeout", cycle_timeout, e.cto);
            chk("spin_timeout",  spin_timeout,  e.sto);
            chk("fault",         fault,         e.fault);
         end
      end
   end

   initial begin
      bit rm;
      reset          = 1'b1;
      tick           = 1'b0;
      fill_valve_on  = 1'b0;
      drain_valve_on = 1'b0;
      motor_on       = 1'b0;
      door_lock      = 1'b1;
      model_reset();
      #12;
      chk("rst_level",   water_level,   0);
      chk("rst_drained", drained,       1);
      chk("rst_filled",  filled,        0);
      chk("rst_cto",     cycle_timeout, 0);
      chk("rst_sto",     spin_timeout,  0);
      chk("rst_fault",   fault,         0);
      step(0, 0, 0, 0, 1, 1);

      // Fill to 120, then reset asynchronously mid-cycle.
      repeat (30) step(1, 1, 0, 0, 1);
      settle();
      chk("fill_120", water_level, 120);
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("async_level",   water_level,   0);
      chk("async_drained", drained,       1);
      chk("async_filled",  filled,        0);
      chk("async_cto",     cycle_timeout, 0);
      chk("async_sto",     spin_timeout,  0);
      chk("async_fault",   fault,         0);
      model_reset();
      step(0, 0, 0, 0, 1, 1);

      // Fill to full, then saturate.
      for (int i = 1; i <= 64; i++) begin
         step(1, 1, 0, 0, 1);
         if (i == 49) begin
            settle();
            chk("fill49_level",  water_level, 196);
            chk("fill49_filled", filled,      0);
         end
         if (i == 50) begin
            settle();
            chk("fill50_level",  water_level, 200);
            chk("fill50_filled", filled,      1);
         end
      end
      settle();
      chk("sat_level", water_level, 255);
      repeat (5) step(1, 1, 0, 0, 1);
      settle();
      chk("sat_hold", water_level, 255);

      // Drain from 200.
      step(0, 0, 0, 0, 1, 1);
      repeat (50) step(1, 1, 0, 0, 1);
      step(1, 0, 1, 0, 1);
      settle();
      chk("drain1_level",  water_level, 192);
      chk("drain1_filled", filled,      0);
      repeat (23) step(1, 0, 1, 0, 1);
      settle();
      chk("drain24_drained", drained, 0);
      step(1, 0, 1, 0, 1);
      settle();
      chk("drain25_level",   water_level, 0);
      chk("drain25_drained", drained,     1);

      // Wash timeout at level 200.
      repeat (50) step(1, 1, 0, 0, 1);
      step(1, 0, 0, 1, 1);
      repeat (CYC - 1) step(1, 0, 0, 1, 1);
      settle();
      chk("wash_999", cycle_timeout, 0);
      step(1, 0, 0, 1, 1);
      settle();
      chk("wash_1000", cycle_timeout, 1);
      repeat (20) step(1, 0, 0, 1, 1);
      settle();
      chk("wash_hold", cycle_timeout, 1);
      step(1, 0, 0, 0, 1);
      settle();
      chk("wash_fall", cycle_timeout, 0);

      // Spin interrupted after 300 ticks, then restarted.
      repeat (25) step(1, 0, 1, 0, 1);
      step(1, 0, 0, 1, 1);
      repeat (300) step(1, 0, 0, 1, 1);
      step(1, 0, 0, 0, 1);
      step(1, 0, 0, 1, 1);
      repeat (198) step(1, 0, 0, 1, 1);
      settle();
      chk("spin_no_old_500", spin_timeout, 0);
      repeat (301) step(1, 0, 0, 1, 1);
      settle();
      chk("spin_499", spin_timeout, 0);
      step(1, 0, 0, 1, 1);
      settle();
      chk("spin_500", spin_timeout, 1);
      chk("spin_no_cto", cycle_timeout, 0);
      step(1, 0, 0, 0, 1);

      // Both valves on for one tick at level 100.
      step(0, 0, 0, 0, 1, 1);
      repeat (25) step(1, 1, 0, 0, 1);
      step(1, 1, 1, 0, 1);
      settle();
      chk("both_level", water_level, 100);
      repeat (3) step(1, 0, 0, 0, 1);
      settle();
`ifdef WM_PLANT_FAULT_EN
      chk("fault_sticky", fault, 1);
`else
      chk("fault_off", fault, 0);
`endif

      // Randomized traffic: short motor bursts first, then long ones so
      // that phases can run to completion.
      step(0, 0, 0, 0, 1, 1);
      rm = 1'b0;
      for (int i = 0; i < 4500; i++) begin
         if (i < 1500) begin
            if ($urandom_range(0, 19) == 0) rm = ~rm;
         end else begin
            if ($urandom_range(0, 1299) == 0) rm = ~rm;
         end
         step(1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 3) == 0),
              rm,
              ($urandom_range(0, 39) != 0),
              ($urandom_range(0, 999) == 0));
      end

      @(posedge clk);
      #3;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
